// File: rtl/xoodyak_pkg.sv
// Shared opmode codes, widths and the buffered record layout for the Xoodyak output path.
package xoodyak_pkg;

  localparam int TEXT_W = 192;
  localparam int TAG_W  = 128;

  localparam logic [3:0] OP_IDLE    = 4'h0;
  localparam logic [3:0] OP_CRYPT   = 4'h4;
  localparam logic [3:0] OP_DECRYPT = 4'h5;
  localparam logic [3:0] OP_SQUEEZE = 4'h6;
  localparam logic [3:0] OP_SQZKEY  = 4'h8;
  localparam logic [3:0] OP_TAG     = 4'hF;

  typedef struct packed {
    logic [3:0]        rtype;
    logic [2:0]        nwords;
    logic [TEXT_W-1:0] payload;
  } xood_rec_t;

endpackage

// File: rtl/xood_rec_fifo.sv
// Record FIFO with an ordered dual push (push0 lands before push1), a single pop and
// the free-slot count that will hold after this cycle's updates.
module xood_rec_fifo
  import xoodyak_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_push0,
  input  xood_rec_t i_rec0,
  input  logic      i_push1,
  input  xood_rec_t i_rec1,
  input  logic      i_pop,
  output xood_rec_t o_head,
  output logic      o_empty,
  output logic      o_drop,
  output logic [AW:0] o_free_nxt
);

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  xood_rec_t   r_mem [DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] w_count, w_free, w_free_eff, w_wr1;
  logic        w_acc0, w_acc1;

  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_free     = L_DEPTH - w_count;
  // A slot freed by this cycle's pop is immediately reusable by this cycle's push.
  assign w_free_eff = w_free + {{AW{1'b0}}, i_pop};
  assign w_acc0     = i_push0 && (w_free_eff != '0);
  assign w_acc1     = i_push1 && (w_free_eff > (AW+1)'(1));
  assign w_wr1      = r_wr_ptr + (AW+1)'(1);

  assign o_drop     = (i_push0 & ~w_acc0) | (i_push1 & ~w_acc1);
  assign o_free_nxt = w_free_eff - {{AW{1'b0}}, w_acc0} - {{AW{1'b0}}, w_acc1};
  assign o_empty    = (w_count == '0);
  assign o_head     = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, w_acc0} + {{AW{1'b0}}, w_acc1};
      r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, i_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_acc0) r_mem[r_wr_ptr[AW-1:0]] <= i_rec0;
    if (w_acc1) r_mem[w_wr1[AW-1:0]]    <= i_rec1;
  end

endmodule

// File: rtl/xoodyak_out_serializer.sv
// Buffers text/tag records from the Xoodyak core and streams them MSB-word-first to the host.
// Optional macro XOOD_TAG_CHECK_EN adds an expected_tag comparator with tag_ok/tag_fail pulses.
module xoodyak_out_serializer
  import xoodyak_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int WORD_W = 32
) (
  input  logic              eph1,
  input  logic              reset,
  input  logic [191:0]      textout_r,
  input  logic              textout_valid,
  input  logic [3:0]        text_op,
  input  logic [127:0]      authdata_o,
  input  logic              auth_valid,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [3:0]        out_type,
  output logic              core_stall,
  output logic              overflow
`ifdef XOOD_TAG_CHECK_EN
  ,
  input  logic [127:0]      expected_tag,
  output logic              tag_ok,
  output logic              tag_fail
`endif
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [2:0] L_NW_TEXT = 3'(TEXT_W / WORD_W);
  localparam logic [2:0] L_NW_TAG  = 3'(TAG_W / WORD_W);

  xood_rec_t   w_text_rec, w_tag_rec, w_rec0, w_head;
  logic        w_push0, w_push1, w_pop, w_empty, w_drop, w_hs, w_last;
  logic [AW:0] w_free_nxt;
  logic [2:0]  r_idx;
  logic        r_overflow, r_core_stall;

  assign w_text_rec = '{rtype: text_op, nwords: L_NW_TEXT, payload: textout_r};
  assign w_tag_rec  = '{rtype: OP_TAG, nwords: L_NW_TAG,
                        payload: {authdata_o, {(TEXT_W-TAG_W){1'b0}}}};

  // Text always rides push0 so a same-cycle tag queues behind it and is the one dropped.
  assign w_push0 = textout_valid | auth_valid;
  assign w_rec0  = textout_valid ? w_text_rec : w_tag_rec;
  assign w_push1 = textout_valid & auth_valid;

  xood_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk      (eph1),
    .i_rst      (reset),
    .i_push0    (w_push0),
    .i_rec0     (w_rec0),
    .i_push1    (w_push1),
    .i_rec1     (w_tag_rec),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_empty    (w_empty),
    .o_drop     (w_drop),
    .o_free_nxt (w_free_nxt)
  );

  assign w_last = (r_idx == (w_head.nwords - 3'd1));
  assign w_hs   = out_valid & out_ready;
  assign w_pop  = w_hs & w_last;

  // Outputs are forced to zero while empty so stale slot contents never leak out.
  assign out_valid  = ~w_empty;
  assign out_data   = out_valid ? w_head.payload[TEXT_W-1-WORD_W*r_idx -: WORD_W] : '0;
  assign out_last   = out_valid & w_last;
  assign out_type   = out_valid ? w_head.rtype : 4'h0;
  assign core_stall = r_core_stall;
  assign overflow   = r_overflow;

  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      r_idx        <= '0;
      r_overflow   <= 1'b0;
      r_core_stall <= 1'b0;
    end else begin
      if (w_hs) r_idx <= w_last ? 3'd0 : r_idx + 3'd1;
      if (w_drop) r_overflow <= 1'b1;
      r_core_stall <= (w_free_nxt < (AW+1)'(2));
    end
  end

`ifdef XOOD_TAG_CHECK_EN
  logic r_tag_ok, r_tag_fail;

  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      r_tag_ok   <= 1'b0;
      r_tag_fail <= 1'b0;
    end else begin
      r_tag_ok   <= auth_valid & (authdata_o == expected_tag);
      r_tag_fail <= auth_valid & (authdata_o != expected_tag);
    end
  end

  assign tag_ok   = r_tag_ok;
  assign tag_fail = r_tag_fail;
`endif

endmodule

// File: tb/tb_xoodyak_out_serializer.sv
// Self-checking bench: word-level queue model of the output stream plus directed scenarios.
`timescale 1ns/1ps
module tb_xoodyak_out_serializer;

  localparam int DEPTH = 2;

  logic         eph1 = 1'b0;
  logic         reset = 1'b0;
  logic [191:0] textout_r = '0;
  logic         textout_valid = 1'b0;
  logic [3:0]   text_op = 4'h0;
  logic [127:0] authdata_o = '0;
  logic         auth_valid = 1'b0;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;
  logic [3:0]   out_type;
  logic         core_stall;
  logic         overflow;
`ifdef XOOD_TAG_CHECK_EN
  logic [127:0] expected_tag = '0;
  logic         tag_ok;
  logic         tag_fail;
`endif

  xoodyak_out_serializer #(.DEPTH(DEPTH), .WORD_W(32)) dut (
    .eph1(eph1), .reset(reset), .textout_r(textout_r), .textout_valid(textout_valid),
    .text_op(text_op), .authdata_o(authdata_o), .auth_valid(auth_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_type(out_type), .core_stall(core_stall), .overflow(overflow)
`ifdef XOOD_TAG_CHECK_EN
    , .expected_tag(expected_tag), .tag_ok(tag_ok), .tag_fail(tag_fail)
`endif
  );

  always #5 eph1 = ~eph1;

  // Reference model: every expected output word in order, plus whole-record occupancy.
  typedef struct packed {
    logic [3:0]  t;
    logic        last;
    logic [31:0] d;
  } word_t;

  word_t       mq[$];
  int          m_cnt;
  logic        m_ovf;
  int          n_cmp, n_bad;
  logic [39:0] g_vec, e_vec, msk;

  function automatic logic [39:0] exp_out();
    if (mq.size() == 0) return 40'h0;
    return {1'b1, mq[0].last, mq[0].t, mq[0].d};
  endfunction

  function automatic logic stall_exp();
    return (DEPTH - m_cnt) < 2;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_push(input logic [3:0] t, input logic [191:0] p, input int nw);
    if (m_cnt < DEPTH) begin
      for (int k = 0; k < nw; k++)
        mq.push_back('{t: t, last: (k == nw - 1), d: p[191-32*k -: 32]});
      m_cnt++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  // Advance model by one clock using the inputs currently driven, then move to the next negedge.
  task automatic tick();
    word_t w;
    if (mq.size() > 0 && out_ready) begin
      w = mq.pop_front();
      if (w.last) m_cnt--;
    end
    if (textout_valid) model_push(text_op, textout_r, 6);
    if (auth_valid)    model_push(4'hF, {authdata_o, 64'h0}, 4);
    @(posedge eph1);
    @(negedge eph1);
    textout_valid = 1'b0;
    auth_valid    = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    #1 reset = 1'b1;
    #2;
    g_vec = {out_valid, out_last, out_type, out_data};
    n_cmp++;
    if (g_vec !== 40'h0) begin
      n_bad++; $display("FAIL reset_outputs got=%h want=%h", g_vec, 40'h0);
    end
    n_cmp++;
    if ({overflow, core_stall} !== 2'b00) begin
      n_bad++; $display("FAIL reset_flags got=%b want=00", {overflow, core_stall});
    end
    repeat (2) @(negedge eph1);
    reset = 1'b0;
    model_clear();
    @(negedge eph1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_release_valid got=%b want=0", out_valid);
    end
  endtask

  task automatic test_single();
    int nw, nl;
    logic [31:0] first_d, last_d;
    nw = 0; nl = 0; first_d = '0; last_d = '0;
    textout_r = 192'h87a06d5561b0d87c20a12db5d34783258ff75fe5d87c0e30;
    text_op = 4'h5; textout_valid = 1'b1; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      g_vec = {out_valid, out_last, out_type, out_data};
      e_vec = exp_out();
      msk = (mq.size() > 0) ? '1 : {1'b1, 39'h0};
      n_cmp++;
      if ((g_vec & msk) !== (e_vec & msk)) begin
        n_bad++; $display("FAIL single_stream cyc=%0d got=%h want=%h", i, g_vec, e_vec);
      end
      n_cmp++;
      if ({overflow, core_stall} !== {m_ovf, stall_exp()}) begin
        n_bad++; $display("FAIL single_flags cyc=%0d got=%b want=%b", i, {overflow, core_stall}, {m_ovf, stall_exp()});
      end
      if (out_valid && out_ready) begin
        if (nw == 0) first_d = out_data;
        if (out_last) begin nl++; last_d = out_data; end
        nw++;
      end
      tick();
    end
    n_cmp++;
    if (nw !== 6 || nl !== 1) begin
      n_bad++; $display("FAIL single_count words=%0d lasts=%0d want 6/1", nw, nl);
    end
    n_cmp++;
    if (first_d !== 32'h87a06d55 || last_d !== 32'hd87c0e30) begin
      n_bad++; $display("FAIL single_ends got=%h/%h want=87a06d55/d87c0e30", first_d, last_d);
    end
  endtask

  task automatic test_backpressure();
    logic [191:0] rec;
    logic [31:0]  seen [$];
    rec = 192'h87a06d5561b0d87c20a12db5d34783258ff75fe5d87c0e30;
    textout_r = rec; text_op = 4'h5; textout_valid = 1'b1; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      g_vec = {out_valid, out_last, out_type, out_data};
      e_vec = exp_out();
      msk = (mq.size() > 0) ? '1 : {1'b1, 39'h0};
      n_cmp++;
      if ((g_vec & msk) !== (e_vec & msk)) begin
        n_bad++; $display("FAIL bp_stream cyc=%0d got=%h want=%h", i, g_vec, e_vec);
      end
      if (out_valid && out_ready) seen.push_back(out_data);
      tick();
    end
    n_cmp++;
    if (seen.size() !== 6) begin
      n_bad++; $display("FAIL bp_count got=%0d want=6", seen.size());
    end
    for (int k = 0; k < 6 && k < seen.size(); k++) begin
      n_cmp++;
      if (seen[k] !== rec[191-32*k -: 32]) begin
        n_bad++; $display("FAIL bp_word%0d got=%h want=%h", k, seen[k], rec[191-32*k -: 32]);
      end
    end
  endtask

  task automatic test_text_tag();
    int nw, ntag, nl;
    nw = 0; ntag = 0; nl = 0;
    textout_r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    text_op = 4'h4; textout_valid = 1'b1;
    authdata_o = 128'h0123456789abcdef0123456789abcdef; auth_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (core_stall !== 1'b1) begin
      n_bad++; $display("FAIL tt_stall_after_push got=%b want=1", core_stall);
    end
    for (int i = 0; i < 12; i++) begin
      g_vec = {out_valid, out_last, out_type, out_data};
      e_vec = exp_out();
      msk = (mq.size() > 0) ? '1 : {1'b1, 39'h0};
      n_cmp++;
      if ((g_vec & msk) !== (e_vec & msk)) begin
        n_bad++; $display("FAIL tt_stream cyc=%0d got=%h want=%h", i, g_vec, e_vec);
      end
      n_cmp++;
      if ({overflow, core_stall} !== {m_ovf, stall_exp()}) begin
        n_bad++; $display("FAIL tt_flags cyc=%0d got=%b want=%b", i, {overflow, core_stall}, {m_ovf, stall_exp()});
      end
      if (out_valid && out_ready) begin
        nw++;
        if (out_type == 4'hF) ntag++;
        if (out_last) nl++;
      end
      tick();
    end
    n_cmp++;
    if (nw !== 10 || ntag !== 4 || nl !== 2) begin
      n_bad++; $display("FAIL tt_count words=%0d tag=%0d lasts=%0d want 10/4/2", nw, ntag, nl);
    end
  endtask

  task automatic test_overflow();
    int nhs;
    nhs = 0;
    out_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      textout_r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      text_op = 4'h6; textout_valid = 1'b1;
      tick();
    end
    n_cmp++;
    if (overflow !== 1'b1 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL ovf_set got ovf=%b valid=%b want 1/1", overflow, out_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      g_vec = {out_valid, out_last, out_type, out_data};
      e_vec = exp_out();
      msk = (mq.size() > 0) ? '1 : {1'b1, 39'h0};
      n_cmp++;
      if ((g_vec & msk) !== (e_vec & msk)) begin
        n_bad++; $display("FAIL ovf_stream cyc=%0d got=%h want=%h", i, g_vec, e_vec);
      end
      if (out_valid && out_ready) nhs++;
      tick();
    end
    n_cmp++;
    if (nhs !== 12) begin
      n_bad++; $display("FAIL ovf_words got=%0d want=12", nhs);
    end
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++; $display("FAIL ovf_sticky got=%b want=1", overflow);
    end
  endtask

  task automatic test_reset_mid();
    logic [191:0] rec2;
    textout_r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    text_op = 4'h8; textout_valid = 1'b1; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    #2 reset = 1'b1;
    #1;
    g_vec = {out_valid, out_last, out_type, out_data};
    n_cmp++;
    if (g_vec !== 40'h0) begin
      n_bad++; $display("FAIL rmid_outputs got=%h want=%h", g_vec, 40'h0);
    end
    n_cmp++;
    if ({overflow, core_stall} !== 2'b00) begin
      n_bad++; $display("FAIL rmid_flags got=%b want=00", {overflow, core_stall});
    end
    model_clear();
    @(posedge eph1);
    @(negedge eph1);
    reset = 1'b0;
    rec2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    textout_r = rec2; text_op = 4'h4; textout_valid = 1'b1;
    tick();
    n_cmp++;
    if (out_data !== rec2[191:160] || out_last !== 1'b0 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL rmid_first got=%h want=%h", out_data, rec2[191:160]);
    end
    for (int i = 0; i < 7; i++) begin
      g_vec = {out_valid, out_last, out_type, out_data};
      e_vec = exp_out();
      msk = (mq.size() > 0) ? '1 : {1'b1, 39'h0};
      n_cmp++;
      if ((g_vec & msk) !== (e_vec & msk)) begin
        n_bad++; $display("FAIL rmid_stream cyc=%0d got=%h want=%h", i, g_vec, e_vec);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [3:0] ops [4];
    ops[0] = 4'h4; ops[1] = 4'h5; ops[2] = 4'h6; ops[3] = 4'h8;
    for (int i = 0; i < 500; i++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      g_vec = {out_valid, out_last, out_type, out_data};
      e_vec = exp_out();
      msk = (mq.size() > 0) ? '1 : {1'b1, 39'h0};
      n_cmp++;
      if ((g_vec & msk) !== (e_vec & msk)) begin
        n_bad++; $display("FAIL rnd_stream cyc=%0d got=%h want=%h", i, g_vec, e_vec);
      end
      n_cmp++;
      if ({overflow, core_stall} !== {m_ovf, stall_exp()}) begin
        n_bad++; $display("FAIL rnd_flags cyc=%0d got=%b want=%b", i, {overflow, core_stall}, {m_ovf, stall_exp()});
      end
      textout_r     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      text_op       = ops[$urandom_range(0, 3)];
      textout_valid = ($urandom_range(0, 3) == 0);
      authdata_o    = {$urandom, $urandom, $urandom, $urandom};
      auth_valid    = ($urandom_range(0, 4) == 0);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      g_vec = {out_valid, out_last, out_type, out_data};
      e_vec = exp_out();
      msk = (mq.size() > 0) ? '1 : {1'b1, 39'h0};
      n_cmp++;
      if ((g_vec & msk) !== (e_vec & msk)) begin
        n_bad++; $display("FAIL rnd_drain cyc=%0d got=%h want=%h", i, g_vec, e_vec);
      end
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b0 || mq.size() != 0) begin
      n_bad++; $display("FAIL rnd_empty got valid=%b want 0 (model left %0d)", out_valid, mq.size());
    end
  endtask

`ifdef XOOD_TAG_CHECK_EN
  task automatic test_tag_check();
    int ntag;
    ntag = 0;
    out_ready = 1'b0;
    expected_tag = {$urandom, $urandom, $urandom, $urandom};
    authdata_o = expected_tag; auth_valid = 1'b1;
    tick();
    n_cmp++;
    if ({tag_ok, tag_fail} !== 2'b10) begin
      n_bad++; $display("FAIL tag_match got=%b want=10", {tag_ok, tag_fail});
    end
    authdata_o = expected_tag ^ (128'h1 << $urandom_range(0, 127)); auth_valid = 1'b1;
    tick();
    n_cmp++;
    if ({tag_ok, tag_fail} !== 2'b01) begin
      n_bad++; $display("FAIL tag_mismatch got=%b want=01", {tag_ok, tag_fail});
    end
    tick();
    n_cmp++;
    if ({tag_ok, tag_fail} !== 2'b00) begin
      n_bad++; $display("FAIL tag_pulse_end got=%b want=00", {tag_ok, tag_fail});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      g_vec = {out_valid, out_last, out_type, out_data};
      e_vec = exp_out();
      msk = (mq.size() > 0) ? '1 : {1'b1, 39'h0};
      n_cmp++;
      if ((g_vec & msk) !== (e_vec & msk)) begin
        n_bad++; $display("FAIL tag_stream cyc=%0d got=%h want=%h", i, g_vec, e_vec);
      end
      if (out_valid && out_ready && out_type == 4'hF) ntag++;
      tick();
    end
    n_cmp++;
    if (ntag !== 8) begin
      n_bad++; $display("FAIL tag_queued got=%0d want=8", ntag);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_clear();
    test_reset();
    test_single();
    test_backpressure();
    test_text_tag();
    test_overflow();
    test_reset_mid();
    test_random();
`ifdef XOOD_TAG_CHECK_EN
    test_tag_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
